// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and encodings for the register-file write path.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_REGS / RF_CNT_W : default sizes
//   req_t   : requester id (REQ_A = ALU writeback, REQ_B = load writeback)
//   state_t : write-port owner state (ST_CLEAR = zero-fill, ST_RUN = arbitrate)
package rf_pkg;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_CNT_W    = 16;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a valid/ready handshake.
//   clk, rst          : clock, async active-low reset
//   en                : arbitration enabled (no grants while low)
//   a_valid, b_valid  : request lines
//   a_grant, b_grant  : one-hot-or-zero grant (combinational), doubles as ready
// The grant is a function of the valids and the last winner only, so a
// requester's payload can never influence whether it is accepted.
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);
    req_t rr_last;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        a_grant = en & a_valid & (~b_valid | (rr_last == REQ_B));
        b_grant = en & b_valid & (~a_valid | (rr_last == REQ_A));
    end

    // Reset to B so A wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last <= REQ_B;
        end else if (a_grant) begin
            rr_last <= REQ_A;
        end else if (b_grant) begin
            rr_last <= REQ_B;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: sole owner of the register file write port.
// After reset it zero-fills registers 0..NUM_REGS-1 (one per cycle), then
// round-robin arbitrates between A (ALU writeback) and B (load writeback).
//   clk, rst                 : clock, async active-low reset
//   a_valid/a_reg/a_data     : requester A, a_ready = accepted this cycle
//   b_valid/b_reg/b_data     : requester B, b_ready = accepted this cycle
//   write/write_reg/write_data : registered register file write port
//   init_done                : zero-fill complete, arbitration active
//   conflict_cnt             : saturating count of RUN cycles with both valid
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int CNT_W    = RF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_RUN),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_grant (a_ready),
        .b_grant (b_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_CLEAR;
            idx          <= '0;
            write        <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            init_done    <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    write      <= 1'b1;
                    write_reg  <= idx;
                    write_data <= '0;
                    idx        <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= ST_RUN;
                end
                ST_RUN: begin
                    // Rises one edge after the last clear write is issued.
                    init_done <= 1'b1;
                    if (a_valid && b_valid && (conflict_cnt != '1))
                        conflict_cnt <= conflict_cnt + 1'b1;
                    if (a_ready) begin
                        write      <= 1'b1;
                        write_reg  <= a_reg;
                        write_data <= a_data;
                    end else if (b_ready) begin
                        write      <= 1'b1;
                        write_reg  <= b_reg;
                        write_data <= b_data;
                    end else begin
                        // Address and data hold; only the enable drops.
                        write <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed + randomized bench with a behavioural model.
module tb_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_reg, b_reg;
    logic [DW-1:0] a_data, b_data;
    logic          write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          init_done;
    logic [CW-1:0] conflict_cnt;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .write(write), .write_reg(write_reg), .write_data(write_data),
        .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: cycles since reset, who won last, expected port.
    int            m_cycles;
    int            m_last;     // 0 = A, 1 = B
    int            m_cnt;
    logic          m_write, m_init;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic          m_ga, m_gb;
    string         grants;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cycles = 0; m_last = 1; m_cnt = 0;
        m_write = 0; m_init = 0; m_reg = '0; m_data = '0;
        m_ga = 0; m_gb = 0;
    endtask

    // Who the spec says should be accepted in the current cycle.
    task automatic model_grant();
        bit running = (m_cycles >= NR);
        m_ga = 0; m_gb = 0;
        if (running) begin
            if (a_valid && b_valid) begin
                if (m_last == 1) m_ga = 1; else m_gb = 1;
            end else begin
                m_ga = a_valid;
                m_gb = b_valid;
            end
        end
    endtask

    task automatic model_edge();
        bit running = (m_cycles >= NR);
        if (!running) begin
            m_write = 1; m_reg = AW'(m_cycles); m_data = '0;
        end else begin
            if (a_valid && b_valid && m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_ga) begin
                m_write = 1; m_reg = a_reg; m_data = a_data; m_last = 0;
            end else if (m_gb) begin
                m_write = 1; m_reg = b_reg; m_data = b_data; m_last = 1;
            end else begin
                m_write = 0;
            end
        end
        m_init = running;
        m_cycles++;
    endtask

    // One clock: check readies mid-cycle, take the edge, check the port.
    task automatic tick();
        #2;
        model_grant();
        chk("a_ready", 64'(a_ready), 64'(m_ga));
        chk("b_ready", 64'(b_ready), 64'(m_gb));
        @(posedge clk);
        model_edge();
        #1;
        chk("write", 64'(write), 64'(m_write));
        chk("write_reg", 64'(write_reg), 64'(m_reg));
        chk("write_data", 64'(write_data), 64'(m_data));
        chk("init_done", 64'(init_done), 64'(m_init));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    task automatic chk_zero_outputs();
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_write_reg", 64'(write_reg), 64'd0);
        chk("rst_write_data", 64'(write_data), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd0);
    endtask

    // Protocol-respecting random traffic: a pending request is held until accepted.
    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (!a_valid || m_ga) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_reg   = AW'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid || m_gb) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_reg   = AW'($urandom);
                b_data  = $urandom;
            end
        end
    endtask

    initial begin
        rst = 0; a_valid = 0; b_valid = 0;
        a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
        model_reset();
        #1;
        chk_zero_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;

        // Zero-fill with A already waiting.
        a_valid = 1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        for (int i = 0; i < NR; i++) begin
            tick();
            chk("clear_reg_seq", 64'(write_reg), 64'(i));
        end
        chk("init_before_run", 64'(init_done), 64'd0);
        tick();
        chk("held_a_reg", 64'(write_reg), 64'd5);
        chk("held_a_data", 64'(write_data), 64'hDEADBEEF);
        chk("init_after_run", 64'(init_done), 64'd1);
        a_valid = 0;
        tick();
        chk("idle_write", 64'(write), 64'd0);

        // B once so A is next under contention, then 6 contention cycles.
        b_valid = 1; b_reg = 5'd7; b_data = 32'h22;
        tick();
        a_valid = 1; a_reg = 5'd3; a_data = 32'h11;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("contend_order", 64'(write_reg), (i % 2 == 0) ? 64'd3 : 64'd7);
        end
        chk("contend_cnt6", 64'(conflict_cnt), 64'd6);

        // B burst, single A, then contention goes to B.
        a_valid = 0;
        grants = "";
        for (int i = 0; i < 4; i++) begin
            tick();
            grants = {grants, m_gb ? "B" : "-"};
        end
        chk("b_burst", 64'(grants == "BBBB"), 64'd1);
        a_valid = 1; b_valid = 0;
        tick();
        chk("a_single", 64'(write_reg), 64'd3);
        b_valid = 1;
        tick();
        chk("b_wins_after_a", 64'(write_reg), 64'd7);

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) tick();
        chk("cnt_saturated", 64'(conflict_cnt), 64'd15);
        a_valid = 0; b_valid = 0;

        random_traffic(300);

        // Reset mid-RUN with a grant pending.
        a_valid = 1; a_reg = 5'd9; a_data = 32'h1234; b_valid = 0;
        #2;
        chk("pending_grant", 64'(a_ready), 64'd1);
        rst = 0;
        #1;
        chk_zero_outputs();
        model_reset();
        a_valid = 0;
        @(negedge clk);
        rst = 1;
        tick();
        chk("restart_reg0", 64'(write_reg), 64'd0);
        chk("restart_write", 64'(write), 64'd1);
        random_traffic(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sole owner of the register file write port (write, write_reg, write_data).
- After reset it sequences a zero-fill of every register, one register per cycle.
- It then arbitrates between two writeback requesters with round-robin priority and a valid/ready handshake: A is ALU writeback, B is load/memory writeback.
- Sits between the writeback stages and the register file; the register file's own rst input is tied inactive.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width
NUM_REGS, 32, registers cleared in the init sweep (must be <= 2**ADDR_W)
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
a_valid  in  1  requester A has a write pending
a_ready  out  1  A's request is accepted this cycle
a_reg  in  ADDR_W  A's destination register
a_data  in  DATA_W  A's write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B's request is accepted this cycle
b_reg  in  ADDR_W  B's destination register
b_data  in  DATA_W  B's write data
write  out  1  register file write enable
write_reg  out  ADDR_W  register file write address
write_data  out  DATA_W  register file write data
init_done  out  1  zero-fill finished; arbitration active
conflict_cnt  out  CNT_W  count of cycles where both requesters were valid (saturating)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, clear index=0, rr_last=B (so A wins first contention).
  - write=0, write_reg=0, write_data=0, init_done=0, conflict_cnt=0.
- FSM: two states, CLEAR and RUN.
- CLEAR:
  - Each cycle, registered outputs take write=1, write_reg=idx, write_data=0; then idx++.
  - When idx == NUM_REGS-1 is issued, next state is RUN and init_done goes 1 on the following edge.
  - Duration is exactly NUM_REGS cycles of write=1 after reset release.
  - a_ready=b_ready=0 throughout; requests are held, not dropped.
  - conflict_cnt does not count in CLEAR.
- RUN grant (combinational from valids and rr_last):
  - Only A valid: A is granted.
  - Only B valid: B is granted.
  - Both valid: the requester not equal to rr_last is granted.
  - At most one ready is high in any cycle.
  - Ready never depends on the requester's own data.
  - Ready is not asserted when the matching valid is 0.
- Transfer = valid & ready. On transfer:
  - Registered outputs take write=1, write_reg/write_data = the winner's reg/data.
  - rr_last is set to the winner.
- No transfer: write=0 next cycle; write_reg and write_data hold their last values.
- Latency: request accepted at edge N appears on the write port during cycle N+1 and is committed by the register file at edge N+1.
- Throughput: one write per cycle. A continuously valid requester under contention gets exactly every other slot.
- Writes to register 0 are forwarded unchanged; the arbiter applies no address filtering.
- conflict_cnt: +1 on each RUN cycle with a_valid & b_valid; saturates at all-ones, never wraps.
- Requesters must hold valid/reg/data stable until ready. The arbiter does not check this.
- Reset mid-operation (CLEAR or RUN): immediate return to reset values. Any granted-but-unissued write is lost; the zero-fill restarts from index 0.
- No X propagation: outputs are defined every cycle after reset.

Decomposition:
- Shared package rf_pkg:
  - DATA_W/ADDR_W/NUM_REGS constants.
  - Requester-id encoding REQ_A=0, REQ_B=1.
  - State encoding ST_CLEAR=0, ST_RUN=1.
- One natural sub-module: rr_arbiter2.
  - Combinational two-way round-robin grant plus the rr_last flop.
  - Reusable for the later memory-port arbiter.
- Zero-fill counter, output registers and conflict counter stay in rf_write_arbiter.

Test Plan:
- Reset release, no requests, NUM_REGS=32 -> write=1 for exactly 32 cycles with write_reg 0..31 and write_data=0; init_done rises on the 33rd edge; a_ready/b_ready=0 throughout.
- a_valid=1 held during CLEAR (a_reg=5, a_data=0xDEADBEEF) -> a_ready first high in the first RUN cycle; the next cycle shows write=1, write_reg=5, write_data=0xDEADBEEF.
- Both valid continuously for 6 RUN cycles (A: reg 3 / 0x11, B: reg 7 / 0x22) -> grants in order A,B,A,B,A,B; write_reg sequence 3,7,3,7,3,7; conflict_cnt=6.
- Single-requester bursts: B alone for 4 cycles, then A alone for 1 cycle, then both -> B,B,B,B,A, then B wins the contention cycle (rr_last=A); no idle write slots.
- Assert rst for one cycle mid-RUN while a grant is pending -> outputs zero immediately (asynchronously); after release the zero-fill restarts at write_reg=0; conflict_cnt=0.
- Force conflict_cnt to near max with CNT_W=4: 20 contention cycles -> conflict_cnt saturates at 15 and stays there.
